// File: rtl/fourbc_pkg.sv
// Shared definitions for the 4-bit counter family (up and down counters).
package fourbc_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_MOD   = 16;
endpackage

// File: rtl/fourbdc_core.sv
// Count register for the down counter: clamped load, modulo decrement, wrap flag.
module fourbdc_core
   import fourbc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int MOD   = DEF_MOD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] eff_d_s;
   logic [WIDTH-1:0] dec_val_s;

   // Clamp the load value and form the modulo-MOD decrement.
   always_comb begin
      eff_d_s   = d;
      dec_val_s = q_r - ONE;
      if (d > MAXV) begin
         eff_d_s = MAXV;
      end else begin
         eff_d_s = d;
      end
      if (q_r == ZERO) begin
         dec_val_s = MAXV;
      end else begin
         dec_val_s = q_r - ONE;
      end
   end

   // Count register: load wins over decrement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r <= ZERO;
      end else if (load) begin
         q_r <= eff_d_s;
      end else if (dec) begin
         q_r <= dec_val_s;
      end else begin
         q_r <= q_r;
      end
   end

   assign q    = q_r;
   assign wrap = dec && (q_r == ZERO) && !load;
endmodule

// File: rtl/sync_fourbdc.sv
// Synchronous down counter with load, modulus, borrow pulse and one-shot mode.
module sync_fourbdc
   import fourbc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int MOD   = DEF_MOD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             bo,
   output logic             busy,
   output logic             done
);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

   state_t           state_r;
   logic             bo_r;
   logic             done_r;
   logic             busy_r;
   logic             dec_s;
   logic             wrap_s;
   logic [WIDTH-1:0] q_s;

   // One-shot mode never wraps, so a zero count there is not decremented.
   always_comb begin
      dec_s = 1'b0;
      if (t && !ld && (state_r != DONE) && (!oneshot || (q_s != ZERO))) begin
         dec_s = 1'b1;
      end else begin
         dec_s = 1'b0;
      end
   end

   fourbdc_core #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .dec   (dec_s),
      .d     (d),
      .q     (q_s),
      .wrap  (wrap_s)
   );

   // Mode FSM with registered busy/done and the borrow pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         bo_r    <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         bo_r <= wrap_s;
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (ld || t) begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               if (!ld && t && oneshot && (q_s <= ONE)) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= RUN;
                  done_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end
            DONE: begin
               // Leaving DONE on a mode drop does not count on that edge.
               if (ld || !oneshot) begin
                  state_r <= RUN;
                  done_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign q    = q_s;
   assign tc   = (q_s == ZERO);
   assign bo   = bo_r;
   assign busy = busy_r;
   assign done = done_r;
endmodule
